data_memory_ctrl: RTL and testbench

Parametrised byte-addressed data memory for the pipelined RV64 core's MEM stage. It serves sized loads and stores (byte, half, word, double) with sign or zero extension and a valid/ready request handshake. Load data is registered, with one cycle of latency. After every reset the block clears its own contents with a sequenced init pass. A debug port lets any doubleword be observed.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_load_extend.sv | 28 ++
 rtl/data_memory_ctrl.sv | 153 +++++++++++++++
 tb/tb_data_memory_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data memory controller.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/dmem_load_extend.sv
// Sign/zero extension of a little-endian raw load value to 64 bits.
module dmem_load_extend
    import dmem_pkg::*;
(
    input  logic [63:0] raw_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [63:0] data_o
);

    logic fill_b, fill_h, fill_w;

    assign fill_b = ~unsigned_i & raw_i[7];
    assign fill_h = ~unsigned_i & raw_i[15];
    assign fill_w = ~unsigned_i & raw_i[31];

    always_comb begin
        data_o = raw_i;
        unique case (size_i)
            SZ_B: data_o = {{56{fill_b}}, raw_i[7:0]};
            SZ_H: data_o = {{48{fill_h}}, raw_i[15:0]};
            SZ_W: data_o = {{32{fill_w}}, raw_i[31:0]};
            SZ_D: data_o = raw_i;
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory with sized loads/stores, self-clearing init pass and debug view.
// Optional macro DMEM_MISALIGN_CHECK_EN rejects accesses not aligned to their size.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 256,
    parameter int ADDR_W      = 64,
    parameter int DBG_IDX_W   = $clog2(DEPTH_BYTES / 8)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [63:0]          req_wdata,
    output logic                 rsp_valid,
    output logic [63:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 init_done,
    input  logic [DBG_IDX_W-1:0] dbg_idx,
    output logic [63:0]          dbg_data
);

    localparam int IDX_W = $clog2(DEPTH_BYTES / 8);
    localparam int BA_W  = IDX_W + 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_BYTES / 8 - 1);

    logic [7:0] mem_q [DEPTH_BYTES];

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              clr_en;

    logic              accept, oob, misalign, err, wr_en;
    logic [BA_W-1:0]   base;
    logic [63:0]       raw_rd;
    logic [IDX_W-1:0]  dbg_sel;

    logic              rsp_valid_q, rsp_err_q, rsp_load_q, uns_q;
    logic [63:0]       raw_q;
    logic [1:0]        size_q;
    logic [63:0]       ext_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_en    = 1'b0;
        req_ready = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                clr_en = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN:  req_ready = 1'b1;
            default: state_d = ST_INIT;
        endcase
    end

    assign init_done = (state_q == ST_RUN);

    assign accept = req_valid && req_ready;
    assign oob    = (req_addr >= ADDR_W'(DEPTH_BYTES));
    assign base   = req_addr[BA_W-1:0];

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign = (req_addr[2:0] & 3'(size_bytes(req_size) - 4'd1)) != 3'd0;
`else
    assign misalign = 1'b0;
`endif

    assign err   = oob | misalign;
    assign wr_en = accept & req_write & ~err;

    // Byte addresses wrap naturally through the BA_W-bit index arithmetic.
    always_comb begin
        raw_rd = '0;
        for (int i = 0; i < 8; i++) begin
            raw_rd[8*i +: 8] = mem_q[base + BA_W'(i)];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clr_en) begin
                for (int i = 0; i < 8; i++) begin
                    mem_q[{cnt_q, 3'(i)}] <= 8'h00;
                end
            end else if (wr_en) begin
                for (int i = 0; i < 8; i++) begin
                    if (4'(i) < size_bytes(req_size)) begin
                        mem_q[base + BA_W'(i)] <= req_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
            raw_q       <= '0;
            size_q      <= SZ_B;
            uns_q       <= 1'b0;
        end else begin
            rsp_valid_q <= accept;
            rsp_err_q   <= accept & err;
            rsp_load_q  <= accept & ~req_write & ~err;
            raw_q       <= raw_rd;
            size_q      <= req_size;
            uns_q       <= req_unsigned;
        end
    end

    dmem_load_extend u_ext (
        .raw_i      (raw_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (ext_data)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_load_q ? ext_data : 64'd0;

    assign dbg_sel = IDX_W'(dbg_idx);

    always_comb begin
        dbg_data = '0;
        for (int i = 0; i < 8; i++) begin
            dbg_data[8*i +: 8] = mem_q[{dbg_sel, 3'(i)}];
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: randomized and directed accesses vs. a byte-array model.
module tb_data_memory_ctrl;

    localparam int DEPTH = 256;
    localparam int NDW   = DEPTH / 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, init_done;
    logic [63:0] rsp_rdata, dbg_data;
    logic [4:0]  dbg_idx;

    data_memory_ctrl #(.DEPTH_BYTES(DEPTH), .ADDR_W(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .init_done    (init_done),
        .dbg_idx      (dbg_idx),
        .dbg_data     (dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint      due;
        logic [63:0] rd;
        bit          err;
    } exp_t;

    exp_t        sbq[$];
    logic [7:0]  mem_m [DEPTH];
    longint      cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          tb_run = 0;

    always @(posedge clk) cyc++;

    function automatic void model_do(input bit w, input logic [1:0] sz, input bit u,
                                     input logic [63:0] a, input logic [63:0] d,
                                     output logic [63:0] rd, output bit err);
        int n;
        n   = 1 << sz;
        rd  = 64'd0;
        err = (a >= 64'(DEPTH));
`ifdef DMEM_MISALIGN_CHECK_EN
        if ((a % 64'(n)) != 0) err = 1;
`endif
        if (!err) begin
            for (int i = 0; i < n; i++) begin
                int idx;
                idx = int'((a + 64'(i)) % 64'(DEPTH));
                if (w) mem_m[idx] = d[8*i +: 8];
                else   rd = rd | (64'(mem_m[idx]) << (8*i));
            end
            if (!w && !u && n < 8 && rd[8*n-1]) rd = rd | ~((64'd1 << (8*n)) - 64'd1);
        end
    endfunction

    task automatic issue(input bit w, input logic [1:0] sz, input bit u,
                         input logic [63:0] a, input logic [63:0] d);
        exp_t e;
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = d;
        if (tb_run && !reset) begin
            model_do(w, sz, u, a, d, e.rd, e.err);
            e.due = cyc + 1;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic check_dbg(input int idx);
        logic [63:0] exp_v;
        exp_v = '0;
        for (int i = 0; i < 8; i++) exp_v[8*i +: 8] = mem_m[8*idx + i];
        dbg_idx = 5'(idx);
        #1;
        n_cmp++;
        if (dbg_data !== exp_v) begin
            n_bad++;
            $display("FAIL dbg_data[%0d]: got %h want %h", idx, dbg_data, exp_v);
        end
    endtask

    task automatic wait_init;
        int lows;
        lows = 0;
        while (init_done !== 1'b1 && lows < 200) begin
            @(negedge clk);
            if (init_done !== 1'b1) lows++;
            n_cmp++;
            if (req_ready !== init_done) begin
                n_bad++;
                $display("FAIL ready_vs_init: ready=%b init_done=%b", req_ready, init_done);
            end
        end
        n_cmp++;
        if (lows != NDW) begin
            n_bad++;
            $display("FAIL init_cycles: got %0d want %0d", lows, NDW);
        end
        @(posedge clk);
        #1;
        tb_run = 1;
    endtask

    always @(negedge clk) begin : monitor
        bit   exp_valid;
        exp_t e;
        exp_valid = (sbq.size() > 0) && (sbq[0].due == cyc);
        if (exp_valid || rsp_valid) begin
            n_cmp++;
            if (rsp_valid !== exp_valid) begin
                n_bad++;
                $display("FAIL rsp_valid @%0d: got %b want %b", cyc, rsp_valid, exp_valid);
            end
        end
        if (exp_valid) begin
            e = sbq.pop_front();
            n_cmp++;
            if (rsp_rdata !== e.rd || rsp_err !== e.err) begin
                n_bad++;
                $display("FAIL rsp_data @%0d: got %h err=%b want %h err=%b",
                         cyc, rsp_rdata, rsp_err, e.rd, e.err);
            end
        end else if (!rsp_valid && (rsp_rdata !== 64'd0 || rsp_err !== 1'b0)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rsp_idle @%0d: got %h err=%b want 0", cyc, rsp_rdata, rsp_err);
        end
    end

    initial begin
        reset = 1'b1;
        req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0;
        req_addr = '0; req_wdata = '0; dbg_idx = '0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (req_ready !== 1'b0 || init_done !== 1'b0 || rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: ready=%b init=%b rsp_valid=%b want 0",
                     req_ready, init_done, rsp_valid);
        end
        reset = 1'b0;
        // Requests during INIT must be ignored; the scoreboard stays empty.
        fork
            wait_init();
            begin
                repeat (4) issue(1'b1, 2'd3, 1'b0, 64'd0, 64'hDEAD_BEEF_DEAD_BEEF);
            end
        join
        for (int i = 0; i < NDW; i++) check_dbg(i);

        issue(1, 2'd3, 0, 64'd8, 64'h8877665544332211);
        issue(0, 2'd0, 0, 64'd9, 64'd0);
        issue(0, 2'd1, 0, 64'd14, 64'd0);
        issue(0, 2'd1, 1, 64'd14, 64'd0);
        check_dbg(1);
        issue(1, 2'd2, 0, 64'd16, 64'h0000_0000_8000_0000);
        issue(0, 2'd2, 0, 64'd16, 64'd0);
        issue(0, 2'd3, 0, 64'd256, 64'd0);
        issue(1, 2'd3, 0, 64'd300, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(1, 2'd3, 0, 64'd3, 64'hA1A2A3A4A5A6A7A8);
        issue(1, 2'd3, 0, 64'd252, 64'hB1B2B3B4B5B6B7B8);
        issue(0, 2'd3, 0, 64'd252, 64'd0);
        issue(0, 2'd1, 0, 64'd255, 64'd0);
        for (int i = 0; i < NDW; i++) check_dbg(i);

        for (int k = 0; k < 400; k++) begin
            logic [63:0] a;
            a = ($urandom_range(0, 15) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 270));
            issue($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
                  a, {$urandom, $urandom});
            if ($urandom_range(0, 7) == 0) check_dbg($urandom_range(0, NDW - 1));
        end
        for (int i = 0; i < NDW; i++) check_dbg(i);

        // Store coinciding with reset must not commit; memory clears again.
        issue(1, 2'd3, 0, 64'd40, 64'h1234_5678_9ABC_DEF0);
        reset     = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3;
        req_addr  = 64'd48; req_wdata = 64'hCAFE_F00D_CAFE_F00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b0;
        tb_run    = 0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_drop: rsp_valid=%b want 0", rsp_valid);
        end
        wait_init();
        for (int i = 0; i < NDW; i++) check_dbg(i);
        issue(0, 2'd3, 0, 64'd40, 64'd0);
        issue(0, 2'd3, 0, 64'd48, 64'd0);

        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: %0d responses never seen, want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
        $finish;
    end

endmodule
